// File: rtl/seg7_pkg.sv
// Shared segment constants and the nibble-to-segment decode used by the
// seven-segment scan driver and its standalone decoder.
//
// Segment bit order: {g,f,e,d,c,b,a}, bit 0 = a, bit 6 = g. All patterns here
// are active-high (1 = segment lit); pin polarity is applied by the driver.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // In BCD mode the non-decimal codes A-F show a dash so bad data is visible.
  function automatic logic [6:0] seg7_decode(input logic [3:0] nibble,
                                             input logic       hex_mode);
    logic [6:0] seg;
    seg = SEG_DASH;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = hex_mode ? SEG_A : SEG_DASH;
      4'hB:    seg = hex_mode ? SEG_B : SEG_DASH;
      4'hC:    seg = hex_mode ? SEG_C : SEG_DASH;
      4'hD:    seg = hex_mode ? SEG_D : SEG_DASH;
      4'hE:    seg = hex_mode ? SEG_E : SEG_DASH;
      default: seg = hex_mode ? SEG_F : SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational single-digit decoder: nibble + mode + blank -> active-high
// segment pattern. Usable on its own wherever one static digit is needed.
module seg7_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       hex_mode_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  // Blanking overrides the decoded glyph entirely.
  assign seg_o = blank_i ? SEG_BLANK : seg7_decode(nibble_i, hex_mode_i);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit seven-segment driver. Holds a shadow copy of
// the display data, scans one digit per CLK_DIV cycles and drives registered,
// polarity-adjusted pin outputs.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_DIV        = 1000,
  parameter bit SEG_ACTIVE_LOW = 1'b0,
  parameter bit DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hex_mode,
  input  logic                    blank_lz,
  output logic [6:0]              Segment,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  // A single-digit build still needs a 1-bit index to keep widths legal.
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [4*NUM_DIGITS-1:0] sh_value_q, sh_value_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic                    sh_hex_q, sh_hex_d;
  logic                    sh_blz_q, sh_blz_d;

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;

  logic [6:0]              seg_out_q, seg_out_d;
  logic                    dp_out_q, dp_out_d;
  logic [NUM_DIGITS-1:0]   dig_out_q, dig_out_d;
  logic                    frame_q, frame_d;

  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   cur_onehot;
  logic [6:0]              cur_seg;

  // Shadow capture: load is honoured regardless of en.
  always_comb begin
    sh_value_d = sh_value_q;
    sh_dp_d    = sh_dp_q;
    sh_hex_d   = sh_hex_q;
    sh_blz_d   = sh_blz_q;
    if (load) begin
      sh_value_d = value;
      sh_dp_d    = dp_in;
      sh_hex_d   = hex_mode;
      sh_blz_d   = blank_lz;
    end
  end

  // Dwell divider and digit index; both park at zero while disabled so a
  // re-enable always starts at digit 0 with a full dwell.
  always_comb begin
    div_cnt_d   = div_cnt_q;
    digit_idx_d = digit_idx_q;
    if (!en) begin
      div_cnt_d   = '0;
      digit_idx_d = '0;
    end else if (div_cnt_q == DIV_LAST) begin
      div_cnt_d   = '0;
      digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + 1'b1;
    end else begin
      div_cnt_d   = div_cnt_q + 1'b1;
    end
  end

  // Pulse marks the last cycle of the last digit, i.e. the end of a frame.
  assign frame_d = en && (div_cnt_q == DIV_LAST) && (digit_idx_q == IDX_LAST);

  // Leading-zero mask: walk from the most significant digit down, staying
  // blank while every digit seen so far is zero with no decimal point.
  always_comb begin
    logic upper_clear;
    upper_clear = 1'b1;
    blank_mask  = '0;
    for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
      upper_clear   = upper_clear && (sh_value_q[4*d +: 4] == 4'h0) && !sh_dp_q[d];
      blank_mask[d] = sh_blz_q && upper_clear;
    end
    blank_mask[0] = 1'b0;
  end

  // Select the data for the digit currently being scanned.
  always_comb begin
    cur_nib    = 4'h0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_onehot = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (digit_idx_q == IDX_W'(d)) begin
        cur_nib       = sh_value_q[4*d +: 4];
        cur_dp        = sh_dp_q[d];
        cur_blank     = blank_mask[d];
        cur_onehot[d] = 1'b1;
      end
    end
  end

  seg7_decoder u_decoder (
    .nibble_i   (cur_nib),
    .hex_mode_i (sh_hex_q),
    .blank_i    (cur_blank),
    .seg_o      (cur_seg)
  );

  // Output register inputs: dark whenever scanning is disabled.
  always_comb begin
    seg_out_d = SEG_BLANK;
    dp_out_d  = 1'b0;
    dig_out_d = '0;
    if (en) begin
      seg_out_d = cur_seg;
      dp_out_d  = cur_dp;
      dig_out_d = cur_onehot;
    end
  end

  // All state, with asynchronous clear to a dark display.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_value_q  <= '0;
      sh_dp_q     <= '0;
      sh_hex_q    <= 1'b0;
      sh_blz_q    <= 1'b0;
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      seg_out_q   <= SEG_BLANK;
      dp_out_q    <= 1'b0;
      dig_out_q   <= '0;
      frame_q     <= 1'b0;
    end else begin
      sh_value_q  <= sh_value_d;
      sh_dp_q     <= sh_dp_d;
      sh_hex_q    <= sh_hex_d;
      sh_blz_q    <= sh_blz_d;
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      seg_out_q   <= seg_out_d;
      dp_out_q    <= dp_out_d;
      dig_out_q   <= dig_out_d;
      frame_q     <= frame_d;
    end
  end

  // Pin polarity sits after the registers so reset levels follow it too.
  assign Segment    = seg_out_q ^ {7{SEG_ACTIVE_LOW}};
  assign dp         = dp_out_q ^ SEG_ACTIVE_LOW;
  assign digit_en   = dig_out_q ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};
  assign frame_done = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: 4 digits, 4-cycle dwell. Instance A uses
// active-high pins and is scoreboarded digit by digit; instance B shares the
// inputs with both polarities inverted.
module tb_seg7_scan_driver;

  localparam int ND = 4;
  localparam int CD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          load = 1'b0;
  logic [15:0]   value = '0;
  logic [3:0]    dp_in = '0;
  logic          hex_mode = 1'b0;
  logic          blank_lz = 1'b0;

  logic [6:0]    seg_a, seg_b;
  logic          dp_a, dp_b;
  logic [3:0]    den_a, den_b;
  logic          fd_a, fd_b;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [3:0] den;
    logic [6:0] seg;
    logic       dp;
  } exp_t;

  exp_t sb_q[$];

  seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD),
                     .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .hex_mode(hex_mode), .blank_lz(blank_lz),
    .Segment(seg_a), .dp(dp_a), .digit_en(den_a), .frame_done(fd_a));

  seg7_scan_driver #(.NUM_DIGITS(ND), .CLK_DIV(CD),
                     .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .value(value),
    .dp_in(dp_in), .hex_mode(hex_mode), .blank_lz(blank_lz),
    .Segment(seg_b), .dp(dp_b), .digit_en(den_b), .frame_done(fd_b));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] ref_glyph(input logic [3:0] nib, input logic hex);
    logic [6:0] tab [16];
    tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
            7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    if (!hex && nib > 4'd9) return 7'h40;
    return tab[nib];
  endfunction

  // Expected pin values for the first ndig digits of one frame.
  function automatic void push_frame(input logic [15:0] v, input logic [3:0] dpv,
                                     input logic hex, input logic blz, input int ndig);
    for (int d = 0; d < ndig; d++) begin
      exp_t e;
      logic blank;
      blank = blz && (d != 0);
      for (int k = d; k < ND; k++)
        if (v[4*k +: 4] != 4'h0 || dpv[k]) blank = 1'b0;
      e.den = 4'b0001 << d;
      e.seg = blank ? 7'h00 : ref_glyph(v[4*d +: 4], hex);
      e.dp  = dpv[d];
      sb_q.push_back(e);
    end
  endfunction

  task automatic do_load(input logic [15:0] v, input logic [3:0] dpv,
                         input logic hex, input logic blz);
    value = v; dp_in = dpv; hex_mode = hex; blank_lz = blz; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    en = 1'b1;
    repeat (n) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: pop on every newly lit digit, check dwell and frame pulses.
  logic [3:0] prev_den = '0;
  int         run_len = 0;
  int         gap = 0;
  bit         gap_valid = 1'b0;
  int         pulses = 0;

  always @(negedge clk) begin
    if (den_a !== prev_den) begin
      if (prev_den != 4'h0 && den_a != 4'h0) chk("dwell", run_len, CD);
      if (den_a != 4'h0) begin
        if (sb_q.size() == 0) chk("sb_size", sb_q.size(), 1);
        else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("digit_en", den_a, e.den);
          chk("segment", seg_a, e.seg);
          chk("dp", dp_a, e.dp);
        end
      end
      run_len = 1;
    end else begin
      run_len++;
    end
    prev_den = den_a;

    gap++;
    if (den_a == 4'h0) gap_valid = 1'b0;
    if (fd_a) begin
      pulses++;
      chk("fd_digit", den_a, 4'b1000);
      if (gap_valid) chk("fd_gap", gap, ND * CD);
      gap = 0;
      gap_valid = 1'b1;
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_seg_a", seg_a, 7'h00);
    chk("rst_dp_a", dp_a, 1'b0);
    chk("rst_den_a", den_a, 4'h0);
    chk("rst_fd_a", fd_a, 1'b0);
    chk("rst_seg_b", seg_b, 7'h7F);
    chk("rst_dp_b", dp_b, 1'b1);
    chk("rst_den_b", den_b, 4'hF);
    rst_n = 1'b1;
    @(negedge clk);

    // Free-running after reset: all digits show 0, two frames.
    push_frame(16'h0000, 4'h0, 1'b0, 1'b0, 4);
    push_frame(16'h0000, 4'h0, 1'b0, 1'b0, 4);
    run_cycles(2 * ND * CD);
    chk("fd_count", pulses, 2);

    // 1234 BCD, then a load landing on the frame wrap switches to 00A5 blanked.
    do_load(16'h1234, 4'h0, 1'b0, 1'b0);
    push_frame(16'h1234, 4'h0, 1'b0, 1'b0, 4);
    push_frame(16'h00A5, 4'h0, 1'b0, 1'b1, 4);
    en = 1'b1;
    repeat (ND * CD - 1) @(negedge clk);
    value = 16'h00A5; dp_in = 4'h0; hex_mode = 1'b0; blank_lz = 1'b1; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (ND * CD) @(negedge clk);
    en = 1'b0;
    @(negedge clk);

    // Same value in hex mode.
    do_load(16'h00A5, 4'h0, 1'b1, 1'b1);
    push_frame(16'h00A5, 4'h0, 1'b1, 1'b1, 4);
    run_cycles(ND * CD);

    // All zero with a dp on digit 2 keeps digits 0..2 lit.
    do_load(16'h0000, 4'b0100, 1'b0, 1'b1);
    push_frame(16'h0000, 4'b0100, 1'b0, 1'b1, 4);
    run_cycles(ND * CD);

    // Drop en for one cycle while digit 2 is lit, then restart.
    push_frame(16'h0000, 4'b0100, 1'b0, 1'b1, 3);
    en = 1'b1;
    repeat (2 * CD + 2) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    chk("dark_seg", seg_a, 7'h00);
    chk("dark_den", den_a, 4'h0);
    chk("dark_dp", dp_a, 1'b0);
    chk("dark_den_b", den_b, 4'hF);
    push_frame(16'h0000, 4'b0100, 1'b0, 1'b1, 4);
    run_cycles(ND * CD);

    // Asynchronous reset between edges while digit 1 is lit.
    push_frame(16'h0000, 4'b0100, 1'b0, 1'b1, 2);
    en = 1'b1;
    repeat (CD + 2) @(negedge clk);
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("arst_seg", seg_a, 7'h00);
    chk("arst_den", den_a, 4'h0);
    chk("arst_dp_b", dp_b, 1'b1);
    chk("arst_seg_b", seg_b, 7'h7F);
    chk("arst_den_b", den_b, 4'hF);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Inverted pins while digit 0 shows an 8.
    do_load(16'h0008, 4'h0, 1'b0, 1'b0);
    push_frame(16'h0008, 4'h0, 1'b0, 1'b0, 4);
    en = 1'b1;
    repeat (2) @(negedge clk);
    chk("inv_seg_b", seg_b, 7'h00);
    chk("inv_den_b", den_b, 4'b1110);
    chk("inv_dp_b", dp_b, 1'b1);
    repeat (ND * CD - 2) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);

    chk("sb_left", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
